// File: rtl/sha1_block_engine.sv
// sha1_block_engine: SHA-1 compression of one 512-bit block, UNROLL rounds per clock.
// Latency: out_valid rises 80/UNROLL + 1 edges after the word-15 handshake edge.
// Backpressure: in_ready only in LOAD; digest held in DONE until out_ready.
// Optional macro SHA1_CHAIN_EN: in_first on word 0 selects IV reload (1) or chaining (0).
module sha1_block_engine #(
    parameter int UNROLL         = 1,  // rounds per clock: 1, 2, 4 or 5 (divides 20)
    parameter bit BIG_ENDIAN_OUT = 1   // 1: H0 in out_digest[159:128], 0: H0 in [31:0]
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [159:0] out_digest,
    output logic         busy
);
    localparam logic [31:0] IV [5] = '{32'h67452301, 32'hefcdab89, 32'h98badcfe,
                                       32'h10325476, 32'hc3d2e1f0};
    localparam int         EXT  = 16 + UNROLL;
    localparam logic [6:0] STEP = 7'(UNROLL);
    localparam logic [6:0] LAST = 7'd80;

    typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [6:0]  round_q;
    logic [31:0] a_q, b_q, c_q, d_q, e_q;
    logic [31:0] a_d, b_d, c_d, d_d, e_d;
    logic [31:0] h_q [5];
    logic [31:0] w_q [16];
    logic [31:0] w_d [16];
    logic [31:0] ext [EXT];
    logic        out_valid_q;
    logic        reload_iv;
    logic [6:0]  t_c;
    logic [31:0] f_c, k_c, tmp_c;

    function automatic logic [31:0] rol1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rol5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rol30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

`ifdef SHA1_CHAIN_EN
    // in_first=0 on word 0 keeps the previous digest as the chaining value
    assign reload_iv = in_first;
`else
    // every block starts from the IV; in_first has no effect
    logic unused_in_first;
    assign reload_iv       = 1'b1;
    assign unused_in_first = in_first;
`endif

    // Message schedule: window w_q holds W[t..t+15]; append UNROLL new words and slide
    always_comb begin
        for (int i = 0; i < EXT; i++) ext[i] = 32'h0;
        for (int i = 0; i < 16; i++) ext[i] = w_q[i];
        // later words may depend on words generated earlier in the same cycle
        for (int j = 0; j < UNROLL; j++)
            ext[16+j] = rol1(ext[13+j] ^ ext[8+j] ^ ext[2+j] ^ ext[j]);
        for (int i = 0; i < 16; i++) w_d[i] = ext[i+UNROLL];
    end

    // UNROLL chained SHA-1 rounds starting at round_q
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        d_d   = d_q;
        e_d   = e_q;
        t_c   = 7'd0;
        f_c   = 32'h0;
        k_c   = 32'h0;
        tmp_c = 32'h0;
        for (int j = 0; j < UNROLL; j++) begin
            t_c = round_q + 7'(j);
            if (t_c < 7'd20) begin
                f_c = (b_d & c_d) | (~b_d & d_d);
                k_c = 32'h5a827999;
            end else if (t_c < 7'd40) begin
                f_c = b_d ^ c_d ^ d_d;
                k_c = 32'h6ed9eba1;
            end else if (t_c < 7'd60) begin
                f_c = (b_d & c_d) | (b_d & d_d) | (c_d & d_d);
                k_c = 32'h8f1bbcdc;
            end else begin
                f_c = b_d ^ c_d ^ d_d;
                k_c = 32'hca62c1d6;
            end
            tmp_c = rol5(a_d) + f_c + e_d + k_c + ext[j];
            e_d   = d_d;
            d_d   = c_d;
            c_d   = rol30(b_d);
            b_d   = a_d;
            a_d   = tmp_c;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_LOAD;
        else     state_q <= state_d;
    end

    // Next state and handshake outputs; RUN spends 80/UNROLL round cycles plus one feed-forward cycle
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = !((state_q == ST_LOAD) && (cnt_q == 4'd0));
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (cnt_q == 4'd15)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (round_q == LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Datapath: word loading, round iteration, feed-forward and digest handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 4'd0;
            round_q     <= 7'd0;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            c_q         <= 32'h0;
            d_q         <= 32'h0;
            e_q         <= 32'h0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 5; i++)  h_q[i] <= IV[i];
            for (int i = 0; i < 16; i++) w_q[i] <= 32'h0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_valid) begin
                        for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                        w_q[15] <= in_data;
                        cnt_q   <= cnt_q + 4'd1;  // wraps to 0 after word 15
                        if ((cnt_q == 4'd0) && reload_iv) begin
                            for (int i = 0; i < 5; i++) h_q[i] <= IV[i];
                        end
                        if (cnt_q == 4'd15) begin
                            a_q     <= h_q[0];
                            b_q     <= h_q[1];
                            c_q     <= h_q[2];
                            d_q     <= h_q[3];
                            e_q     <= h_q[4];
                            round_q <= 7'd0;
                        end
                    end
                end
                ST_RUN: begin
                    if (round_q != LAST) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        c_q     <= c_d;
                        d_q     <= d_d;
                        e_q     <= e_d;
                        round_q <= round_q + STEP;
                        for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
                    end else begin
                        h_q[0]      <= h_q[0] + a_q;
                        h_q[1]      <= h_q[1] + b_q;
                        h_q[2]      <= h_q[2] + c_q;
                        h_q[3]      <= h_q[3] + d_q;
                        h_q[4]      <= h_q[4] + e_q;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: out_valid_q <= 1'b0;
            endcase
        end
    end

    // Digest word ordering
    always_comb begin
        if (BIG_ENDIAN_OUT) out_digest = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};
        else                out_digest = {h_q[4], h_q[3], h_q[2], h_q[1], h_q[0]};
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sha1_block_engine.sv
// tb_sha1_block_engine: checks four engines (UNROLL 1,2,4,5) fed in parallel against a behavioural SHA-1 model.
// Latency: measured per engine from the word-15 handshake edge to out_valid.
// Backpressure: in_valid gaps during LOAD, out_ready held low in DONE.
module tb_sha1_block_engine;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_first;
    logic [3:0]   out_rdy;
    logic [3:0]   in_rdy, ov, bsy;
    logic [159:0] dig [4];
    int           edges = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    localparam int           UN [4] = '{1, 2, 4, 5};
    localparam logic [159:0] IVD    = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    typedef struct packed {
        logic [511:0] blk;
        logic [159:0] dig;
    } vec_t;

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    sha1_block_engine #(.UNROLL(1), .BIG_ENDIAN_OUT(1)) u_e1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]), .in_data(in_data),
        .in_first(in_first), .out_valid(ov[0]), .out_ready(out_rdy[0]), .out_digest(dig[0]), .busy(bsy[0]));
    sha1_block_engine #(.UNROLL(2), .BIG_ENDIAN_OUT(0)) u_e2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]), .in_data(in_data),
        .in_first(in_first), .out_valid(ov[1]), .out_ready(out_rdy[1]), .out_digest(dig[1]), .busy(bsy[1]));
    sha1_block_engine #(.UNROLL(4), .BIG_ENDIAN_OUT(1)) u_e4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]), .in_data(in_data),
        .in_first(in_first), .out_valid(ov[2]), .out_ready(out_rdy[2]), .out_digest(dig[2]), .busy(bsy[2]));
    sha1_block_engine #(.UNROLL(5), .BIG_ENDIAN_OUT(1)) u_e5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[3]), .in_data(in_data),
        .in_first(in_first), .out_valid(ov[3]), .out_ready(out_rdy[3]), .out_digest(dig[3]), .busy(bsy[3]));

    // Reference SHA-1 compression straight from the FIPS 180 definition (80-word schedule)
    function automatic logic [159:0] sha1_model(input logic [159:0] hin, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp, x;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = (x << 1) | (x >> 31);
        end
        a = hin[159:128]; b = hin[127:96]; c = hin[95:64]; d = hin[63:32]; e = hin[31:0];
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            tmp = ((a << 5) | (a >> 27)) + f + e + k + w[t];
            e = d; d = c; c = (b << 30) | (b >> 2); b = a; a = tmp;
        end
        return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction

    // Engine 1 is built with H0 in the low word
    function automatic logic [159:0] order(input int k, input logic [159:0] be);
        if (k == 1) return {be[31:0], be[63:32], be[95:64], be[127:96], be[159:128]};
        return be;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Present words 0..n-1 of blk, optionally with random in_valid gaps; returns the edge count of the last handshake
    task automatic send_words(input logic [511:0] blk, input logic first, input int n,
                              input bit gaps, output int e_last);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_data  = blk[511-32*i -: 32];
                in_first = (i == 0) ? first : 1'($urandom);
            end
            acc = in_valid && in_rdy[0];
            @(posedge clk);
            if (acc) i++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        e_last   = edges;
        if (guard >= 2000) chk_int("send_stall", i, n);
    endtask

    // Collect each engine's digest and latency, optionally hold out_ready low, then hand the digest off
    task automatic wait_digest(input string nm, input logic [159:0] exp_be, input int e15, input int hold);
        int           lat [4];
        logic [159:0] d [4];
        bit           stable [4];
        bit           done_all;
        for (int k = 0; k < 4; k++) begin
            lat[k] = -1; d[k] = '0; stable[k] = 1'b1;
        end
        chk({nm, "_busy"}, 160'(bsy), 160'hf);
        for (int c = 0; c < 300; c++) begin
            done_all = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (lat[k] < 0 && ov[k]) begin
                    lat[k] = edges - e15;
                    d[k]   = dig[k];
                end
                if (lat[k] < 0) done_all = 1'b0;
            end
            if (done_all) break;
            @(negedge clk);
        end
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (ov[k] !== 1'b1 || dig[k] !== d[k] || in_rdy[k] !== 1'b0) stable[k] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_digest_U%0d", nm, UN[k]), d[k], order(k, exp_be));
            chk_int($sformatf("%s_latency_U%0d", nm, UN[k]), lat[k], 80 / UN[k] + 1);
            if (hold > 0) chk($sformatf("%s_hold_U%0d", nm, UN[k]), 160'(stable[k]), 160'h1);
        end
        chk({nm, "_in_ready_done"}, 160'(in_rdy), 160'h0);
        out_rdy = 4'hf;
        @(negedge clk);
        out_rdy = 4'h0;
        chk({nm, "_in_ready_after"}, 160'(in_rdy), 160'hf);
        chk({nm, "_valid_cleared"}, 160'(ov), 160'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t         tab [2];
        logic [511:0] abc_blk, nist1, nist2, rblk;
        logic [159:0] abc_dig;
        int           e;

        abc_blk = {32'h61626380, {14{32'h0}}, 32'h00000018};
        abc_dig = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
        nist1   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        nist2   = {{15{32'h0}}, 32'h000001c0};
        tab[0].blk = abc_blk;
        tab[0].dig = abc_dig;
        tab[1].blk = {32'h80000000, {15{32'h0}}};
        tab[1].dig = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;

        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_first = 1'b0; out_rdy = 4'h0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_in_ready_U%0d", UN[k]), 160'(in_rdy[k]), 160'h1);
            chk($sformatf("reset_valid_U%0d", UN[k]), 160'(ov[k]), 160'h0);
            chk($sformatf("reset_busy_U%0d", UN[k]), 160'(bsy[k]), 160'h0);
            chk($sformatf("reset_digest_U%0d", UN[k]), dig[k], order(k, IVD));
        end
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vectors
        for (int v = 0; v < 2; v++) begin
            send_words(tab[v].blk, 1'b1, 16, 1'b0, e);
            wait_digest($sformatf("kat%0d", v), tab[v].dig, e, 0);
        end

        // Consumer stall in DONE, with input gaps during LOAD
        send_words(abc_blk, 1'b1, 16, 1'b1, e);
        wait_digest("hold", abc_dig, e, 50);

        // Reset around round 40 of the UNROLL=1 engine (later engines already done)
        send_words(tab[1].blk, 1'b1, 16, 1'b0, e);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("runrst_valid", 160'(ov), 160'h0);
        chk("runrst_in_ready", 160'(in_rdy), 160'hf);
        chk("runrst_busy", 160'(bsy), 160'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("runrst_no_spurious", 160'(ov), 160'h0);
        send_words(abc_blk, 1'b1, 16, 1'b0, e);
        wait_digest("after_runrst", abc_dig, e, 0);

        // Reset part-way through loading: next word is word 0 again
        for (int i = 0; i < 16; i++) rblk[511-32*i -: 32] = $urandom;
        send_words(rblk, 1'b1, 7, 1'b0, e);
        chk("loadrst_busy", 160'(bsy), 160'hf);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_words(abc_blk, 1'b1, 16, 1'b0, e);
        wait_digest("after_loadrst", abc_dig, e, 0);

        // Two-block message: in_first 1 then 0
        send_words(nist1, 1'b1, 16, 1'b0, e);
        wait_digest("chain_blk1", sha1_model(IVD, nist1), e, 0);
        send_words(nist2, 1'b0, 16, 1'b0, e);
`ifdef SHA1_CHAIN_EN
        wait_digest("chain_blk2", 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1, e, 0);
`else
        wait_digest("nochain_blk2", sha1_model(IVD, nist2), e, 0);
`endif

        // Random blocks with random in_valid gaps
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) rblk[511-32*i -: 32] = $urandom;
            send_words(rblk, 1'b1, 16, 1'b1, e);
            wait_digest($sformatf("rand%0d", r), sha1_model(IVD, rblk), e, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sha1_block_engine.md
SHA1_BLOCK_ENGINE -- requirements
Module: sha1_block_engine

Interface
REQ-001 The block SHALL have parameter UNROLL, default 1: SHA-1 rounds evaluated per clock; legal values 1, 2, 4, 5.
REQ-002 The block SHALL have parameter BIG_ENDIAN_OUT, default 1: 1 places H0 in out_digest[159:128], 0 places H0 in out_digest[31:0].
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, message word valid.
REQ-006 The block SHALL have port in_ready, output, 1, engine accepts a word this cycle.
REQ-007 The block SHALL have port in_data, input, 32, message word W[t], word 0 first.
REQ-008 The block SHALL have port in_first, input, 1, sampled with word 0 only: 1 means first block of a message.
REQ-009 The block SHALL have port out_valid, output, 1, digest valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts the digest.
REQ-011 The block SHALL have port out_digest, output, 160, H0..H4 after feed-forward.
REQ-012 The block SHALL have port busy, output, 1, high in any state other than LOAD with word count 0.

Function
REQ-013 The FSM SHALL have three states: LOAD, RUN and DONE.
REQ-014 In LOAD, in_ready SHALL be 1 and a word SHALL be accepted on each edge with in_valid=1, incrementing a 4-bit word count.
REQ-015 Acceptance of word 15 SHALL move the FSM to RUN, wrap the word count to 0, and copy H into working registers A..E.
REQ-016 RUN SHALL last exactly 80/UNROLL cycles; each cycle SHALL perform UNROLL sequential standard SHA-1 rounds t..t+UNROLL-1.
REQ-017 Rounds SHALL select function and constant as follows: t 0-19 Ch with K 5a827999; t 20-39 parity with K 6ed9eba1; t 40-59 Maj with K 8f1bbcdc; t 60-79 parity with K ca62c1d6.
REQ-018 The W schedule SHALL be a 16-word sliding window; for t>=16, W[t] = rol1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), with UNROLL words generated per cycle.
REQ-019 All additions SHALL be modulo 2^32, with no saturation and no carry out.
REQ-020 The edge after the last RUN cycle SHALL compute H[i] <= H[i] + working[i], drive out_digest, assert out_valid and enter DONE.
REQ-021 Latency SHALL be out_valid high exactly 80/UNROLL + 1 edges after the word-15 handshake edge.
REQ-022 In RUN and DONE, in_ready SHALL be 0.
REQ-023 out_valid and out_digest SHALL hold stable in DONE until out_ready=1; that edge SHALL clear out_valid and return to LOAD.
REQ-024 in_ready SHALL be 1 in the cycle after the digest handshake; back-to-back blocks therefore cost 16 + 80/UNROLL + 2 cycles each.
REQ-025 in_valid=0 in LOAD SHALL stall without loss; a partially loaded block SHALL be retained indefinitely.

Reset
REQ-026 rst=1 SHALL immediately force state LOAD, word count 0, out_valid 0, busy 0, in_ready 1, and H to IV 67452301 efcdab89 98badcfe 10325476 c3d2e1f0.
REQ-027 After reset, out_digest SHALL equal IV in the BIG_ENDIAN_OUT ordering.
REQ-028 Reset mid-LOAD or mid-RUN SHALL abandon the block with no digest produced; the first word after release SHALL be treated as word 0.
REQ-029 Reset deassertion SHALL be synchronised externally; the block SHALL NOT self-synchronise.

Configuration
REQ-030 The block SHALL support macro SHA1_CHAIN_EN.
REQ-031 With SHA1_CHAIN_EN defined, in_first=0 on word 0 SHALL keep H from the previous digest (multi-block chaining), and in_first=1 SHALL reload H to IV at that edge.
REQ-032 Without SHA1_CHAIN_EN, in_first SHALL be ignored and H SHALL be reloaded to IV at every word-0 acceptance.

Verification
REQ-033 Scenario: padded "abc" block, UNROLL=1 -> digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, out_valid 81 edges after word 15.
REQ-034 Scenario: padded empty message, UNROLL=5 -> digest da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709, latency 17 edges.
REQ-035 Scenario: SHA1_CHAIN_EN defined, 448-bit NIST message as two blocks with in_first 1 then 0 -> digest 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
REQ-036 Scenario: out_ready held 0 for 50 cycles in DONE -> out_valid and out_digest stable, in_ready 0; release -> in_ready 1 on the next cycle.
REQ-037 Scenario: rst pulsed during RUN round 40, then the "abc" block is sent -> no spurious out_valid, correct "abc" digest.
REQ-038 Scenario: in_valid toggled randomly during LOAD for UNROLL in {1, 2, 4} -> identical digests; latency 81, 41 and 21 edges respectively.
